mem_stage: RTL and testbench

- Receiving end of the EX-stage result interface for the 16-bit THCO MIPS pipeline.
- Registers the ALU result, write-enable and destination register (the MEM/WB latch) for the writeback stage.
- Runs a multi-cycle load/store transaction on the external SRAM bus when the instruction is a memory op, and holds the upstream pipeline with a stall request until the transaction finishes.

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_stage_sram.sv | 106 ++++++++++
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths and memory-op codes for the MEM stage of
// the 16-bit THCO MIPS pipeline.
//   reg_bus_t       16-bit datapath word (RegBus)
//   reg_addr_bus_t  4-bit register index (RegAddrBus)
//   mem_op_bus_t    2-bit memory-op code carried from EX (MemOpBus)
//   ram_addr_bus_t  default-width external SRAM address (RamAddrBus)
package mem_stage_pkg;

  typedef logic [15:0] reg_bus_t;
  typedef logic [3:0]  reg_addr_bus_t;
  typedef logic [1:0]  mem_op_bus_t;

  localparam reg_bus_t ZERO_WORD = 16'h0000;

  localparam mem_op_bus_t MEM_NONE  = 2'b00;
  localparam mem_op_bus_t MEM_LOAD  = 2'b01;
  localparam mem_op_bus_t MEM_STORE = 2'b10;

  localparam int RAM_ADDR_W_DEF = 18;
  typedef logic [RAM_ADDR_W_DEF-1:0] ram_addr_bus_t;

  // Counter wide enough for the largest legal WAIT_CYCLES (15).
  localparam int CNT_W = 4;

  // The reserved code 2'b11 is deliberately not a memory op.
  function automatic logic is_mem_op(input mem_op_bus_t op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_stage_sram.sv
// sram_ctrl: multi-cycle load/store sequencer for the external async SRAM.
//   clk, rst        clock, synchronous active-low reset
//   start           begin a transaction (only honoured in IDLE)
//   op              memory-op code latched at start
//   addr, wdata     address and store data latched at start
//   idle            FSM is in IDLE (new transaction may start)
//   busy            FSM is in ACCESS (bus cycles in progress)
//   done            last ACCESS cycle; the closing edge ends the access
//   rdata           SRAM read data, valid while done is high on a load
//   ram_*           SRAM pins (address, write data, read data, CE/OE/WE active low)
// WAIT_CYCLES must lie in 2..15.
module sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_ADDR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  mem_op_bus_t           op,
  input  reg_bus_t              addr,
  input  reg_bus_t              wdata,
  output logic                  idle,
  output logic                  busy,
  output logic                  done,
  output reg_bus_t              rdata,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output reg_bus_t              ram_wdata,
  input  reg_bus_t              ram_rdata,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_p1;
  reg_bus_t         addr_p1;
  reg_bus_t         wdata_p1;

  // Stage p1: transaction fields captured when the access is accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      store_p1 <= 1'b0;
      addr_p1  <= ZERO_WORD;
      wdata_p1 <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start && (state_q == S_IDLE)) begin
        store_p1 <= (op == MEM_STORE);
        addr_p1  <= addr;
        wdata_p1 <= wdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        if (start) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      S_ACCESS: begin
        busy     = 1'b1;
        ram_ce_n = 1'b0;
        ram_oe_n = store_p1;
        // WE releases one cycle early so data is held past the write strobe.
        ram_we_n = !(store_p1 && (cnt_q != '0));
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata     = ram_rdata;
  assign ram_addr  = RAM_ADDR_W'(addr_p1);
  assign ram_wdata = wdata_p1;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 16-bit THCO MIPS pipeline. Holds the MEM/WB
// latch and drives loads/stores onto the external SRAM via sram_ctrl,
// stalling upstream while a transaction is in flight.
//   clk, rst                     clock, synchronous active-low reset
//   wData_i/wReg_i/wRegAddr_i    EX result (address for memory ops), write enable, dest reg
//   memOp_i, memData_i           memory-op code and store data
//   wData_o/wReg_o/wRegAddr_o    MEM/WB latch towards writeback
//   stallReq_o                   combinational upstream freeze
//   ramAddr_o, ramWData_o, ramRData_i, ramCe_n_o, ramOe_n_o, ramWe_n_o  SRAM bus
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_ADDR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  reg_bus_t              wData_i,
  input  logic                  wReg_i,
  input  reg_addr_bus_t         wRegAddr_i,
  input  mem_op_bus_t           memOp_i,
  input  reg_bus_t              memData_i,
  output reg_bus_t              wData_o,
  output logic                  wReg_o,
  output reg_addr_bus_t         wRegAddr_o,
  output logic                  stallReq_o,
  output logic [RAM_ADDR_W-1:0] ramAddr_o,
  output reg_bus_t              ramWData_o,
  input  reg_bus_t              ramRData_i,
  output logic                  ramCe_n_o,
  output logic                  ramOe_n_o,
  output logic                  ramWe_n_o
);

  logic          ctrl_idle;
  logic          ctrl_busy;
  logic          ctrl_done;
  reg_bus_t      ctrl_rdata;
  logic          start;
  logic          wreg_p1;
  reg_addr_bus_t wregaddr_p1;
  logic          load_p1;

  // A memory op seen in IDLE starts the access; anything arriving while the
  // controller is in DONE is the same instruction still sitting upstream.
  assign start      = ctrl_idle && is_mem_op(memOp_i);
  assign stallReq_o = start || ctrl_busy;

  sram_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_sram_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (memOp_i),
    .addr     (wData_i),
    .wdata    (memData_i),
    .idle     (ctrl_idle),
    .busy     (ctrl_busy),
    .done     (ctrl_done),
    .rdata    (ctrl_rdata),
    .ram_addr (ramAddr_o),
    .ram_wdata(ramWData_o),
    .ram_rdata(ramRData_i),
    .ram_ce_n (ramCe_n_o),
    .ram_oe_n (ramOe_n_o),
    .ram_we_n (ramWe_n_o)
  );

  // Stage p1: MEM/WB latch plus the writeback fields parked during an access
  always_ff @(posedge clk) begin
    if (!rst) begin
      wData_o     <= ZERO_WORD;
      wReg_o      <= 1'b0;
      wRegAddr_o  <= '0;
      wreg_p1     <= 1'b0;
      wregaddr_p1 <= '0;
      load_p1     <= 1'b0;
    end else if (start) begin
      wreg_p1     <= wReg_i;
      wregaddr_p1 <= wRegAddr_i;
      load_p1     <= (memOp_i == MEM_LOAD);
      wReg_o      <= 1'b0;
    end else if (ctrl_idle) begin
      wData_o    <= wData_i;
      wReg_o     <= wReg_i;
      wRegAddr_o <= wRegAddr_i;
    end else if (ctrl_done) begin
      if (load_p1) begin
        wData_o    <= ctrl_rdata;
        wReg_o     <= wreg_p1;
        wRegAddr_o <= wregaddr_p1;
      end else begin
        wReg_o <= 1'b0;
      end
    end else if (!ctrl_busy) begin
      // DONE cycle: the result has been shown once; drop back to a bubble.
      wReg_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int W   = 2;
  localparam int RAW = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       wData_i = '0;
  logic              wReg_i = 1'b0;
  logic [3:0]        wRegAddr_i = '0;
  logic [1:0]        memOp_i = '0;
  logic [15:0]       memData_i = '0;
  logic [15:0]       wData_o;
  logic              wReg_o;
  logic [3:0]        wRegAddr_o;
  logic              stallReq_o;
  logic [RAW-1:0]    ramAddr_o;
  logic [15:0]       ramWData_o;
  logic [15:0]       ramRData_i;
  logic              ramCe_n_o;
  logic              ramOe_n_o;
  logic              ramWe_n_o;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_CYCLES(W), .RAM_ADDR_W(RAW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wData_i   (wData_i),
    .wReg_i    (wReg_i),
    .wRegAddr_i(wRegAddr_i),
    .memOp_i   (memOp_i),
    .memData_i (memData_i),
    .wData_o   (wData_o),
    .wReg_o    (wReg_o),
    .wRegAddr_o(wRegAddr_o),
    .stallReq_o(stallReq_o),
    .ramAddr_o (ramAddr_o),
    .ramWData_o(ramWData_o),
    .ramRData_i(ramRData_i),
    .ramCe_n_o (ramCe_n_o),
    .ramOe_n_o (ramOe_n_o),
    .ramWe_n_o (ramWe_n_o)
  );

  // Initial memory image shared by the SRAM model and the reference model.
  function automatic logic [15:0] init_val(input int i);
    if (i == 8'h40) return 16'hBEEF;
    return 16'(i * 16'h0101) ^ 16'h3C00;
  endfunction

  // SRAM model decodes the low 8 address bits; reads return 16'hDEAD when OE is off.
  logic [15:0] sram [0:255];
  logic        sram_ready = 1'b0;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
      sram_ready <= 1'b1;
    end else if (!ramCe_n_o && !ramWe_n_o) begin
      sram[ramAddr_o[7:0]] <= ramWData_o;
    end
  end
  always_comb ramRData_i = ramOe_n_o ? 16'hDEAD : sram[ramAddr_o[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  addr;
    int          due;
  } wb_t;

  wb_t         exp_q[$];
  logic [15:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every cycle showing wReg_o=1 is one writeback.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst && wReg_o !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got writeback data %h reg %0d at cycle %0d, required none",
                   wData_o, wRegAddr_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", 32'(wData_o), 32'(e.data));
          chk("wb_reg", 32'(wRegAddr_o), 32'(e.addr));
          chk("wb_cycle", cyc, e.due);
        end
      end
    end
  end

  // Present one instruction and hold it until the stage stops stalling.
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic wr,
                       input logic [3:0] ra, input logic [15:0] md);
    int   c0, n_stall, n_ce, n_oe, n_we, n_badaddr, n_baddata, guard;
    logic accepted, is_load, is_store;
    wb_t  e;
    is_load  = (op == MEM_LOAD);
    is_store = (op == MEM_STORE);
    memOp_i = op; wData_i = d; wReg_i = wr; wRegAddr_i = ra; memData_i = md;
    c0 = cyc;
    if (is_load) begin
      if (wr) begin
        e.data = ref_mem[d[7:0]]; e.addr = ra; e.due = c0 + W + 1;
        exp_q.push_back(e);
      end
    end else if (is_store) begin
      ref_mem[d[7:0]] = md;
    end else if (wr) begin
      e.data = d; e.addr = ra; e.due = c0 + 1;
      exp_q.push_back(e);
    end
    n_stall = 0; n_ce = 0; n_oe = 0; n_we = 0; n_badaddr = 0; n_baddata = 0; guard = 0;
    accepted = 1'b0;
    do begin
      @(negedge clk);
      if (stallReq_o) n_stall++;
      if (!ramCe_n_o) begin
        n_ce++;
        if (ramAddr_o !== RAW'(d)) n_badaddr++;
      end
      if (!ramOe_n_o) n_oe++;
      if (!ramWe_n_o) begin
        n_we++;
        if (ramWData_o !== md) n_baddata++;
      end
      accepted = (stallReq_o === 1'b0);
      @(posedge clk);
      #1;
      guard++;
    end while (!accepted && guard < 40);
    chk("accepted", 32'(accepted), 32'd1);
    chk("stall_cycles", n_stall, (is_load || is_store) ? W + 1 : 0);
    chk("ce_cycles", n_ce, (is_load || is_store) ? W : 0);
    chk("oe_cycles", n_oe, is_load ? W : 0);
    chk("we_cycles", n_we, is_store ? W - 1 : 0);
    chk("ram_addr_bad", n_badaddr, 0);
    chk("ram_wdata_bad", n_baddata, 0);
  endtask

  initial begin : stim
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wdata", 32'(wData_o), 32'd0);
    chk("rst_wreg", 32'(wReg_o), 32'd0);
    chk("rst_wregaddr", 32'(wRegAddr_o), 32'd0);
    chk("rst_stall", 32'(stallReq_o), 32'd0);
    chk("rst_ce", 32'(ramCe_n_o), 32'd1);
    chk("rst_oe", 32'(ramOe_n_o), 32'd1);
    chk("rst_we", 32'(ramWe_n_o), 32'd1);
    chk("rst_ramaddr", 32'(ramAddr_o), 32'd0);
    chk("rst_ramwdata", 32'(ramWData_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed cases
    issue(MEM_NONE, 16'h1234, 1'b1, 4'd3, 16'h0000);
    issue(MEM_LOAD, 16'h0040, 1'b1, 4'd5, 16'h0000);
    issue(MEM_STORE, 16'h0100, 1'b0, 4'd0, 16'hA5A5);
    issue(MEM_LOAD, 16'h0040, 1'b1, 4'd6, 16'h0000);
    issue(MEM_NONE, 16'h0007, 1'b1, 4'd2, 16'h0000);
    issue(2'b11, 16'h00FF, 1'b1, 4'd7, 16'h0000);
    issue(MEM_LOAD, 16'h8100, 1'b1, 4'd4, 16'h0000);

    // Reset during the second ACCESS cycle of a load
    memOp_i = MEM_LOAD; wData_i = 16'h0022; wReg_i = 1'b1; wRegAddr_i = 4'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    memOp_i = MEM_NONE; wReg_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_stall", 32'(stallReq_o), 32'd0);
    chk("abort_ce", 32'(ramCe_n_o), 32'd1);
    chk("abort_oe", 32'(ramOe_n_o), 32'd1);
    chk("abort_we", 32'(ramWe_n_o), 32'd1);
    chk("abort_wreg", 32'(wReg_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      issue(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 16'($urandom));
    end

    repeat (3) issue(MEM_NONE, 16'h0000, 1'b0, 4'd0, 16'h0000);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
